morse_encoder_tx: RTL and testbench

Transmit-side counterpart of the Morse decode path. Accepts one ASCII character per start/ready handshake, converts it to the team's sentinel-coded Morse pattern, and drives a single keyed line (key_out) with standard dot/dash/gap timing scaled by a clock-cycle unit. Sits between a character source (UART RX or test host) and the key/LED/buzzer driver. Its output can be looped back into the detector/decoder chain.

---
 rtl/morse_pkg.sv | 58 +++++
 rtl/morse_code_lut.sv | 30 +++
 rtl/morse_encoder_tx.sv | 149 ++++++++++++++
 tb/tb_morse_encoder_tx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse definitions for the encoder and decoder paths.
// Code format: MSB-side sentinel 1, then elements MSB-first (0=dot, 1=dash); 8'h00 = unmapped.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MARK,
        GAP,
        LGAP,
        WGAP
    } state_e;

    localparam int unsigned DOT_U  = 1;
    localparam int unsigned DASH_U = 3;
    localparam int unsigned IGAP_U = 1;
    localparam int unsigned LGAP_U = 3;
    localparam int unsigned WGAP_U = 4;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] CODE_NONE   = 8'h00;

    // Uppercase letters only; digits are layered on by morse_code_lut when enabled.
    function automatic logic [7:0] ascii_to_code(input logic [7:0] ch);
        logic [7:0] code;
        case (ch)
            8'h41: code = 8'h05; // A .-
            8'h42: code = 8'h18; // B -...
            8'h43: code = 8'h1A; // C -.-.
            8'h44: code = 8'h0C; // D -..
            8'h45: code = 8'h02; // E .
            8'h46: code = 8'h12; // F ..-.
            8'h47: code = 8'h0E; // G --.
            8'h48: code = 8'h10; // H ....
            8'h49: code = 8'h04; // I ..
            8'h4A: code = 8'h17; // J .---
            8'h4B: code = 8'h0D; // K -.-
            8'h4C: code = 8'h14; // L .-..
            8'h4D: code = 8'h07; // M --
            8'h4E: code = 8'h06; // N -.
            8'h4F: code = 8'h0F; // O ---
            8'h50: code = 8'h16; // P .--.
            8'h51: code = 8'h1D; // Q --.-
            8'h52: code = 8'h0A; // R .-.
            8'h53: code = 8'h08; // S ...
            8'h54: code = 8'h03; // T -
            8'h55: code = 8'h09; // U ..-
            8'h56: code = 8'h11; // V ...-
            8'h57: code = 8'h0B; // W .--
            8'h58: code = 8'h19; // X -..-
            8'h59: code = 8'h1B; // Y -.--
            8'h5A: code = 8'h1C; // Z --..
            default: code = CODE_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/morse_code_lut.sv
// Combinational ASCII -> sentinel-coded Morse lookup.
// Digits '0'-'9' are mapped only when MORSE_DIGITS_EN is defined.
module morse_code_lut
    import morse_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [7:0] code
);

    // Letter table from the package, optionally extended with digits
    always_comb begin
        code = ascii_to_code(ascii);
`ifdef MORSE_DIGITS_EN
        case (ascii)
            8'h30: code = 8'h3F;
            8'h31: code = 8'h2F;
            8'h32: code = 8'h27;
            8'h33: code = 8'h23;
            8'h34: code = 8'h21;
            8'h35: code = 8'h20;
            8'h36: code = 8'h30;
            8'h37: code = 8'h38;
            8'h38: code = 8'h3C;
            8'h39: code = 8'h3E;
            default: ;
        endcase
`endif
    end

endmodule

// File: rtl/morse_encoder_tx.sv
// Morse transmitter: one ASCII character per start/ready handshake, keyed on key_out
// with dot/dash/gap timing scaled by UNIT_CYCLES. Digit support via MORSE_DIGITS_EN (in morse_code_lut).
module morse_encoder_tx
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ascii,
    input  logic       start,
    output logic       ready,
    output logic       key_out,
    output logic       done,
    output logic       err
);

    localparam int unsigned CNT_W = $clog2(7 * UNIT_CYCLES + 1);

    // Cycle counter reload value for a duration given in Morse units
    function automatic logic [CNT_W-1:0] unit_cycles(input int unsigned units);
        return CNT_W'(units * UNIT_CYCLES - 1);
    endfunction

    state_e           state_q, state_d;
    logic [7:0]       ascii_q, ascii_d;
    logic [6:0]       shift_q, shift_d;   // bit 6 = current element
    logic [2:0]       elem_q, elem_d;     // elements remaining incl. current
    logic [CNT_W-1:0] cnt_q, cnt_d;       // cycles left in current mark/gap
    logic             key_q, key_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [7:0]       code_c;
    logic [2:0]       sent_pos_c;
    logic [6:0]       shift_ld_c;

    morse_code_lut u_lut (
        .ascii (ascii_q),
        .code  (code_c)
    );

    // Sentinel position = element count; align first element to shift bit 6
    always_comb begin
        sent_pos_c = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (code_c[i]) sent_pos_c = 3'(i);
        end
        shift_ld_c = 7'(code_c << (3'd7 - sent_pos_c));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        ascii_d = ascii_q;
        shift_d = shift_q;
        elem_d  = elem_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ascii_d = ascii;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (ascii_q == ASCII_SPACE) begin
                    cnt_d   = unit_cycles(WGAP_U);
                    state_d = WGAP;
                end else if (code_c == CODE_NONE) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    shift_d = shift_ld_c;
                    elem_d  = sent_pos_c;
                    cnt_d   = unit_cycles(shift_ld_c[6] ? DASH_U : DOT_U);
                    state_d = MARK;
                end
            end
            MARK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (elem_q > 3'd1) begin
                    cnt_d   = unit_cycles(IGAP_U);
                    state_d = GAP;
                end else begin
                    cnt_d   = unit_cycles(LGAP_U);
                    state_d = LGAP;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = shift_q << 1;
                    elem_d  = elem_q - 1'b1;
                    cnt_d   = unit_cycles(shift_q[5] ? DASH_U : DOT_U);
                    state_d = MARK;
                end
            end
            LGAP, WGAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        key_d   = (state_d == MARK);
        ready_d = (state_d == IDLE);
        done_d  = ((state_d == LGAP) || (state_d == WGAP)) && (cnt_d == '0);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ascii_q <= '0;
            shift_q <= '0;
            elem_q  <= '0;
            cnt_q   <= '0;
            key_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ascii_q <= ascii_d;
            shift_q <= shift_d;
            elem_q  <= elem_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign key_out = key_q;
    assign ready   = ready_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_morse_encoder_tx.sv
// Directed self-checking bench for morse_encoder_tx (UNIT_CYCLES=4).
// Define MORSE_DIGITS_EN for both RTL and bench to exercise digit codes.
module tb_morse_encoder_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ascii;
    logic       start;
    logic       ready;
    logic       key_out;
    logic       done;
    logic       err;

    int n_assert = 0;
    int n_fail   = 0;
    int pat[$];

    morse_encoder_tx #(.UNIT_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .ascii   (ascii),
        .start   (start),
        .ready   (ready),
        .key_out (key_out),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Compare {ready,key_out,done,err} against an expected vector
    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {ready, key_out, done, err};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: rdy/key/done/err=%b expected %b", tag, obs, exp);
        end
    endtask

    // Present a character for one accepting edge; returns at the LOAD-cycle negedge
    task automatic send(input logic [7:0] ch, input string tag);
        @(negedge clk);
        ascii = ch;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_load"}, 4'b0000);
    endtask

    // Walk the run-length pattern in pat, alternating levels; done only on the final cycle
    task automatic play(input string tag, input logic first_level, input int inject);
        int total;
        int cyc;
        logic level;
        total = 0;
        foreach (pat[i]) total += pat[i];
        cyc   = 0;
        level = first_level;
        foreach (pat[i]) begin
            for (int k = 0; k < pat[i]; k++) begin
                @(negedge clk);
                check(tag, {1'b0, level, (cyc == total - 1), 1'b0});
                if (inject >= 0) begin
                    start = (cyc == inject);
                    ascii = 8'h4D;
                end
                cyc++;
            end
            level = ~level;
        end
        @(negedge clk);
        check({tag, "_idle"}, 4'b1000);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ascii = 8'h00;
        repeat (3) @(negedge clk);
        check("reset", 4'b1000);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset", 4'b1000);

        // E: dot then letter gap
        send(8'h45, "E");
        pat = '{4, 12};
        play("E", 1'b1, -1);

        // A and B
        send(8'h41, "A");
        pat = '{4, 4, 12, 12};
        play("A", 1'b1, -1);
        send(8'h42, "B");
        pat = '{12, 4, 4, 4, 4, 4, 4, 12};
        play("B", 1'b1, -1);

        // T followed by word space
        send(8'h54, "T");
        pat = '{12, 12};
        play("T", 1'b1, -1);
        send(8'h20, "SP");
        pat = '{16};
        play("SP", 1'b0, -1);

        // Unmapped lowercase
        send(8'h61, "a");
        @(negedge clk);
        check("a_err", 4'b1001);
        @(negedge clk);
        check("a_after", 4'b1000);

`ifdef MORSE_DIGITS_EN
        send(8'h30, "D0");
        pat = '{12, 4, 12, 4, 12, 4, 12, 4, 12, 12};
        play("D0", 1'b1, -1);
`else
        send(8'h31, "d1");
        @(negedge clk);
        check("d1_err", 4'b1001);
        @(negedge clk);
        check("d1_after", 4'b1000);
`endif

        // Start held high: E accepted twice back to back
        @(negedge clk);
        ascii = 8'h45;
        start = 1'b1;
        @(negedge clk);
        check("held1_load", 4'b0000);
        pat = '{4, 12};
        play("held1", 1'b1, -1);
        @(negedge clk);
        start = 1'b0;
        check("held2_load", 4'b0000);
        play("held2", 1'b1, -1);

        // O with an M strobe during the first dash; M must be ignored
        send(8'h4F, "O");
        pat = '{12, 4, 12, 4, 12, 12};
        play("O", 1'b1, 5);
        start = 1'b0;
        @(negedge clk);
        check("O_noM", 4'b1000);

        // Reset in the middle of a dash aborts without done
        send(8'h54, "Trst");
        repeat (5) begin
            @(negedge clk);
            check("Trst_mark", 4'b0100);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort", 4'b1000);
        repeat (16) begin
            @(negedge clk);
            check("abort_quiet", 4'b1000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
